// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-operation and FSM definitions for the fetch/control stage.
package cpu_pkg;

    localparam logic [5:0] OPC_R   = 6'b000000;
    localparam logic [5:0] OPC_LW  = 6'b100011;
    localparam logic [5:0] OPC_SW  = 6'b101011;
    localparam logic [5:0] OPC_BEQ = 6'b000100;
    localparam logic [5:0] OPC_J   = 6'b000010;
    localparam logic [5:0] OPC_HLT = 6'b111111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        reg_dst:    1'b0,
        alu_src:    1'b0,
        mem_to_reg: 1'b0,
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        alu_op:     ALUOP_ADD
    };

endpackage

// File: rtl/cpu_main_ctrl.sv
// Combinational opcode decoder producing EU control signals and the illegal-opcode flag.
module cpu_main_ctrl
    import cpu_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal_op
);

    // Decode table; unlisted opcodes behave as a NOP and are flagged.
    always_comb begin
        ctrl       = CTRL_NOP;
        illegal_op = 1'b0;
        case (opcode)
            OPC_R: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            OPC_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
            end
            OPC_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OPC_BEQ: begin
                ctrl.alu_op = ALUOP_SUB;
            end
            OPC_J, OPC_HLT: begin
                ctrl = CTRL_NOP;
            end
            default: begin
                illegal_op = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_fetch_ctrl.sv
// Instruction fetch and main control: PC, instruction ROM, next-PC selection,
// RUN/HALT sequencing with stall gating, and the retired-instruction counter.
module cpu_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256,
    parameter string       IMEM_FILE  = "imem.hex"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Zero,
    input  logic [31:0] SEImm,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic [1:0]  ALUOp,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Halted,
    output logic        IllegalOp,
    output logic [31:0] InstCount
);

    localparam int          AW             = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam logic [31:0] IMEM_WORDS_32  = 32'(IMEM_WORDS);

    // ROM contents are preloaded by the surrounding flow (IMEM_FILE image).
    logic [31:0] rom_r [IMEM_WORDS];

    logic [31:0] pc_r;
    logic [31:0] inst_count_r;
    state_t      state_r;

    logic [29:0] word_idx_s;
    logic [31:0] inst_s;
    logic [5:0]  opcode_s;
    logic [31:0] pc4_s;
    logic [31:0] next_pc_s;
    ctrl_t       dec_ctrl_s;
    logic        dec_illegal_s;
    ctrl_t       ctrl_out_s;
    logic        illegal_out_s;

    // Zero-latency ROM read; words past the end of the array read as 0.
    always_comb begin
        word_idx_s = pc_r[31:2];
        if ({2'b00, word_idx_s} < IMEM_WORDS_32) begin
            inst_s = rom_r[word_idx_s[AW-1:0]];
        end else begin
            inst_s = 32'h0000_0000;
        end
    end

    assign opcode_s = inst_s[31:26];
    assign pc4_s    = pc_r + 32'd4;

    cpu_main_ctrl u_main_ctrl (
        .opcode     (opcode_s),
        .ctrl       (dec_ctrl_s),
        .illegal_op (dec_illegal_s)
    );

    // Next-PC selection: jump, taken branch, or sequential.
    always_comb begin
        next_pc_s = pc4_s;
        if (opcode_s == OPC_J) begin
            next_pc_s = {pc4_s[31:28], inst_s[25:0], 2'b00};
        end else if ((opcode_s == OPC_BEQ) && Zero) begin
            next_pc_s = pc4_s + (SEImm << 2);
        end else begin
            next_pc_s = pc4_s;
        end
    end

    // Output gating: nothing escapes during reset or HALT; a stall blocks writes only.
    always_comb begin
        ctrl_out_s    = dec_ctrl_s;
        illegal_out_s = dec_illegal_s;
        if (reset || (state_r == HALT)) begin
            ctrl_out_s    = CTRL_NOP;
            illegal_out_s = 1'b0;
        end else if (Stall) begin
            ctrl_out_s.reg_write = 1'b0;
            ctrl_out_s.mem_write = 1'b0;
        end else begin
            ctrl_out_s    = dec_ctrl_s;
            illegal_out_s = dec_illegal_s;
        end
    end

    // RUN/HALT sequencer with PC and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r         <= RESET_PC;
            inst_count_r <= 32'h0000_0000;
            state_r      <= RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (!Stall) begin
                        if (opcode_s == OPC_HLT) begin
                            state_r <= HALT;
                        end else begin
                            pc_r         <= next_pc_s;
                            inst_count_r <= inst_count_r + 32'd1;
                        end
                    end
                end
                HALT: begin
                    state_r <= HALT;
                end
                default: begin
                    state_r <= HALT;
                end
            endcase
        end
    end

    assign PC          = pc_r;
    assign Instruction = inst_s;
    assign RegDst      = ctrl_out_s.reg_dst;
    assign ALUSrc      = ctrl_out_s.alu_src;
    assign ALUOp       = ctrl_out_s.alu_op;
    assign RegWrite    = ctrl_out_s.reg_write;
    assign MemtoReg    = ctrl_out_s.mem_to_reg;
    assign MemRead     = ctrl_out_s.mem_read;
    assign MemWrite    = ctrl_out_s.mem_write;
    assign Halted      = (state_r == HALT);
    assign IllegalOp   = illegal_out_s;
    assign InstCount   = inst_count_r;

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// Self-checking bench for cpu_fetch_ctrl: directed scenarios plus a randomized run
// against an instruction-level reference model.
module tb_cpu_fetch_ctrl;

    localparam logic [31:0] I_ADD = 32'h0022_1820;
    localparam logic [31:0] I_LW  = 32'h8C22_0004;
    localparam logic [31:0] I_SW  = 32'hAC22_0008;
    localparam logic [31:0] I_BEQ = 32'h1022_0003;
    localparam logic [31:0] I_J   = 32'h0800_0040;
    localparam logic [31:0] I_HLT = 32'hFC00_0000;
    localparam logic [31:0] I_ILL = 32'h3C01_1234;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        Zero;
    logic [31:0] SEImm;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        RegDst, ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite, Halted, IllegalOp;
    logic [1:0]  ALUOp;
    logic [31:0] InstCount;
    logic [7:0]  ctrl_obs;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [256];
    logic [31:0] mpc;
    logic [31:0] mcnt;
    logic        mhalt;

    cpu_fetch_ctrl dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Zero(Zero), .SEImm(SEImm),
        .PC(PC), .Instruction(Instruction), .RegDst(RegDst), .ALUSrc(ALUSrc),
        .ALUOp(ALUOp), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemRead(MemRead),
        .MemWrite(MemWrite), .Halted(Halted), .IllegalOp(IllegalOp), .InstCount(InstCount)
    );

    assign ctrl_obs = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decode table as {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,ALUOp}
    function automatic logic [7:0] table_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return 8'b1001_0010;
            6'h23:   return 8'b0111_1000;
            6'h2B:   return 8'b0100_0100;
            6'h04:   return 8'b0000_0001;
            default: return 8'b0000_0000;
        endcase
    endfunction

    function automatic logic is_known(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
               (op == 6'h04) || (op == 6'h02) || (op == 6'h3F);
    endfunction

    function automatic logic [31:0] m_instr();
        if (mpc[31:2] < 30'd256) return mem[mpc[9:2]];
        return 32'h0;
    endfunction

    function automatic logic [7:0] m_ctrl();
        logic [7:0] c;
        if (reset || mhalt) return 8'h00;
        c = table_ctrl(m_instr() >> 26);
        if (Stall) c = c & 8'b1110_1011;
        return c;
    endfunction

    function automatic logic m_illegal();
        logic [31:0] ins;
        ins = m_instr();
        if (reset || mhalt) return 1'b0;
        return !is_known(ins[31:26]);
    endfunction

    // Instruction-level model of one clock edge.
    task automatic model_step();
        logic [31:0] ins;
        logic [31:0] pc4;
        if (reset) begin
            mpc = 32'h0; mcnt = 32'h0; mhalt = 1'b0;
        end else if (!mhalt && !Stall) begin
            ins = m_instr();
            pc4 = mpc + 32'd4;
            if (ins[31:26] == 6'h3F) begin
                mhalt = 1'b1;
            end else begin
                if (ins[31:26] == 6'h02)               mpc = {pc4[31:28], ins[25:0], 2'b00};
                else if (ins[31:26] == 6'h04 && Zero)  mpc = pc4 + SEImm * 32'd4;
                else                                   mpc = pc4;
                mcnt = mcnt + 32'd1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        mem[idx] = val;
        dut.rom_r[idx] = val;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) set_word(i, 32'h0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; Stall = 1'b0; Zero = 1'b0; SEImm = 32'h0;
        repeat (n) tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_rom();
        set_word(0, I_ADD);
        reset = 1'b1; Stall = 1'b0; Zero = 1'b0; SEImm = 32'h0;
        tick(); tick();
        total++; if (PC !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
        total++; if (InstCount !== 32'h0) begin bad++; $display("FAIL reset_cnt: got %h want %h", InstCount, 32'h0); end
        total++; if (Halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", Halted); end
        total++; if ({RegWrite, MemWrite, MemRead} !== 3'b000) begin bad++; $display("FAIL reset_we: got %b want 000", {RegWrite, MemWrite, MemRead}); end
        reset = 1'b0;
        #1;
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL reset_release_rw: got %b want 1", RegWrite); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4];
        logic [7:0]  exp_c  [3];
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_c  = '{8'b1001_0010, 8'b0111_1000, 8'b0100_0100};
        clear_rom();
        set_word(0, I_ADD); set_word(1, I_LW); set_word(2, I_SW); set_word(3, I_ADD);
        do_reset(2);
        for (int i = 0; i < 3; i++) begin
            total++; if (PC !== exp_pc[i]) begin bad++; $display("FAIL seq_pc[%0d]: got %h want %h", i, PC, exp_pc[i]); end
            total++; if (ctrl_obs !== exp_c[i]) begin bad++; $display("FAIL seq_ctrl[%0d]: got %b want %b", i, ctrl_obs, exp_c[i]); end
            tick();
        end
        total++; if (PC !== exp_pc[3]) begin bad++; $display("FAIL seq_pc_end: got %h want %h", PC, exp_pc[3]); end
        total++; if (InstCount !== 32'd3) begin bad++; $display("FAIL seq_cnt: got %0d want 3", InstCount); end
    endtask

    task automatic test_beq();
        logic        zr  [3];
        logic [31:0] imm [3];
        logic [31:0] exp [3];
        zr  = '{1'b1, 1'b0, 1'b1};
        imm = '{32'd3, 32'd3, 32'hFFFF_FFFE};
        exp = '{32'h18, 32'hC, 32'h4};
        clear_rom();
        set_word(0, I_ADD); set_word(1, I_ADD); set_word(2, I_BEQ);
        for (int i = 0; i < 3; i++) begin
            do_reset(1);
            tick(); tick();
            Zero = zr[i]; SEImm = imm[i];
            #1;
            total++; if (ctrl_obs !== 8'b0000_0001) begin bad++; $display("FAIL beq_ctrl[%0d]: got %b want 00000001", i, ctrl_obs); end
            tick();
            total++; if (PC !== exp[i]) begin bad++; $display("FAIL beq_pc[%0d]: got %h want %h", i, PC, exp[i]); end
        end
        Zero = 1'b0; SEImm = 32'h0;
    endtask

    task automatic test_jump();
        clear_rom();
        for (int i = 0; i < 4; i++) set_word(i, I_ADD);
        set_word(4, I_J);
        do_reset(1);
        repeat (4) tick();
        total++; if (Instruction !== I_J) begin bad++; $display("FAIL j_inst: got %h want %h", Instruction, I_J); end
        tick();
        total++; if (PC !== 32'h100) begin bad++; $display("FAIL j_pc: got %h want %h", PC, 32'h100); end
        total++; if (InstCount !== 32'd5) begin bad++; $display("FAIL j_cnt: got %0d want 5", InstCount); end
    endtask

    task automatic test_stall();
        clear_rom();
        set_word(0, I_ADD); set_word(1, I_ADD);
        do_reset(1);
        Stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (PC !== 32'h0) begin bad++; $display("FAIL stall_pc[%0d]: got %h want 0", i, PC); end
            total++; if (InstCount !== 32'h0) begin bad++; $display("FAIL stall_cnt[%0d]: got %0d want 0", i, InstCount); end
            total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL stall_rw[%0d]: got %b want 0", i, RegWrite); end
            tick();
        end
        Stall = 1'b0;
        #1;
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL stall_release_rw: got %b want 1", RegWrite); end
        tick();
        total++; if (PC !== 32'h4) begin bad++; $display("FAIL stall_release_pc: got %h want 4", PC); end
        total++; if (InstCount !== 32'd1) begin bad++; $display("FAIL stall_release_cnt: got %0d want 1", InstCount); end
    endtask

    task automatic test_halt_illegal_reset();
        clear_rom();
        set_word(0, I_ILL); set_word(1, I_HLT);
        do_reset(1);
        total++; if (IllegalOp !== 1'b1) begin bad++; $display("FAIL ill_flag: got %b want 1", IllegalOp); end
        tick();
        total++; if (PC !== 32'h4) begin bad++; $display("FAIL ill_pc: got %h want 4", PC); end
        total++; if (Halted !== 1'b0) begin bad++; $display("FAIL pre_halt: got %b want 0", Halted); end
        tick();
        for (int i = 0; i < 10; i++) begin
            total++; if (Halted !== 1'b1) begin bad++; $display("FAIL halt_flag[%0d]: got %b want 1", i, Halted); end
            total++; if (PC !== 32'h4) begin bad++; $display("FAIL halt_pc[%0d]: got %h want 4", i, PC); end
            total++; if (InstCount !== 32'd1) begin bad++; $display("FAIL halt_cnt[%0d]: got %0d want 1", i, InstCount); end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++; if (PC !== 32'h0) begin bad++; $display("FAIL halt_reset_pc: got %h want 0", PC); end
        total++; if (Halted !== 1'b0) begin bad++; $display("FAIL halt_reset_flag: got %b want 0", Halted); end
    endtask

    function automatic logic [31:0] rand_inst();
        int          r;
        logic [31:0] low;
        logic [31:0] tgt;
        logic [5:0]  ill;
        r   = $urandom_range(0, 99);
        low = $urandom;
        tgt = $urandom_range(0, 255);
        if (r < 25) return {6'h00, low[25:0]};
        if (r < 40) return {6'h23, low[25:0]};
        if (r < 55) return {6'h2B, low[25:0]};
        if (r < 70) return {6'h04, low[25:0]};
        if (r < 80) return {6'h02, 18'h0, tgt[7:0]};
        if (r < 98) begin
            ill = 6'h0F;
            if (low[31]) ill = 6'h08;
            return {ill, low[25:0]};
        end
        return I_HLT;
    endfunction

    task automatic test_random();
        for (int i = 0; i < 256; i++) set_word(i, rand_inst());
        do_reset(1);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            Stall = ($urandom_range(0, 3) == 0);
            Zero  = 1'($urandom_range(0, 1));
            SEImm = 32'(int'($urandom_range(0, 16)) - 8);
            #1;
            total++; if (PC !== mpc) begin bad++; $display("FAIL rnd_pc[%0d]: got %h want %h", c, PC, mpc); end
            total++; if (Instruction !== m_instr()) begin bad++; $display("FAIL rnd_inst[%0d]: got %h want %h", c, Instruction, m_instr()); end
            total++; if (ctrl_obs !== m_ctrl()) begin bad++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", c, ctrl_obs, m_ctrl()); end
            total++; if (IllegalOp !== m_illegal()) begin bad++; $display("FAIL rnd_ill[%0d]: got %b want %b", c, IllegalOp, m_illegal()); end
            total++; if (Halted !== mhalt) begin bad++; $display("FAIL rnd_halt[%0d]: got %b want %b", c, Halted, mhalt); end
            total++; if (InstCount !== mcnt) begin bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", c, InstCount, mcnt); end
            tick();
        end
        Stall = 1'b0;
    endtask

    initial begin
        reset = 1'b1; Stall = 1'b0; Zero = 1'b0; SEImm = 32'h0;
        mpc = 32'h0; mcnt = 32'h0; mhalt = 1'b0;
        @(negedge clk);
        #1;
        test_reset();
        test_sequential();
        test_beq();
        test_jump();
        test_stall();
        test_halt_illegal_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
